// File: rtl/jc_pkg.sv
// jc_pkg: shared FSM state type and default sizes for the Johnson step controller.
package jc_pkg;
    localparam int JC_WIDTH = 6;
    localparam int JC_STEPW = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/jc_shift_core.sv
// jc_shift_core: bidirectional Johnson shift register with synchronous clear.
module jc_shift_core
    import jc_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] r_q;

    // clear beats shift so a corrupted pattern is never propagated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_q <= '0;
        else if (clr)
            r_q <= '0;
        else if (en)
            r_q <= dir ? {r_q[WIDTH-2:0], ~r_q[WIDTH-1]} : {~r_q[0], r_q[WIDTH-1:1]};
    end

    assign q = r_q;
endmodule

// File: rtl/jc_step_controller.sv
// jc_step_controller: runs N-step Johnson shift commands with abort and phase decode.
// Define JC_SELFHEAL_EN to compile in illegal-pattern detection and reload.
module jc_step_controller
    import jc_pkg::*;
#(
    parameter int WIDTH = JC_WIDTH,
    parameter int STEPW = JC_STEPW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [STEPW-1:0]            cmd_steps,
    input  logic                        cmd_dir,
    input  logic                        abort,
    output logic [WIDTH-1:0]            q,
    output logic [$clog2(2*WIDTH)-1:0]  phase,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic                        err
);
    localparam int PHW = $clog2(2*WIDTH);
    localparam int OW  = $clog2(WIDTH+1);

    state_t           r_state, w_next;
    logic [STEPW-1:0] r_cnt;
    logic             r_dir, r_aborted;
    logic             w_acc, w_stop, w_shift, w_err;
    logic [OW-1:0]    w_ones;

`ifdef JC_SELFHEAL_EN
    // a legal Johnson code has at most one boundary between its run of ones and zeros
    logic [WIDTH-2:0] w_trans;
    assign w_trans = q[WIDTH-1:1] ^ q[WIDTH-2:0];
    assign w_err   = $countones(w_trans) > 1;
`else
    assign w_err = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_acc   = cmd_valid && r_state == IDLE;
        w_stop  = abort || w_err;
        w_shift = r_state == RUN && !w_stop;
        case (r_state)
            IDLE:    if (w_acc) w_next = (cmd_steps != '0) ? RUN : DONE;
            RUN:     if (w_stop || r_cnt == STEPW'(1)) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dir     <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_acc) begin
                r_cnt     <= cmd_steps;
                r_dir     <= cmd_dir;
                r_aborted <= 1'b0;
            end else if (r_state == RUN) begin
                if (w_stop)
                    r_aborted <= 1'b1;
                else
                    r_cnt <= r_cnt - STEPW'(1);
            end
        end
    end

    jc_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk (clk),
        .rst (rst),
        .en  (w_shift),
        .dir (r_dir),
        .clr (w_err),
        .q   (q)
    );

    assign w_ones    = OW'($countones(q));
    assign phase     = (q[0] || q == '0) ? PHW'(w_ones) : PHW'(2*WIDTH - int'(w_ones));
    assign cmd_ready = r_state == IDLE;
    assign busy      = r_state == RUN || r_state == DONE;
    assign done      = r_state == DONE;
    assign aborted   = r_aborted;
    assign err       = w_err;
endmodule

// File: tb/tb_jc_step_controller.sv
// tb_jc_step_controller: directed self-checking bench for jc_step_controller (WIDTH=6, STEPW=8).
module tb_jc_step_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_dir = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cmd_steps = '0;
    logic       cmd_ready, busy, done, aborted, err;
    logic [5:0] q;
    logic [3:0] phase;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jc_step_controller #(.WIDTH(6), .STEPW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_steps (cmd_steps),
        .cmd_dir   (cmd_dir),
        .abort     (abort),
        .q         (q),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err)
    );

    // forward Johnson code after k shifts from zero
    function automatic logic [5:0] fwd(input int k);
        int m;
        m = k % 12;
        return (m <= 6) ? 6'((1 << m) - 1) : 6'(~((1 << (m - 6)) - 1));
    endfunction

    task automatic do_reset;
        rst = 1'b0;
        cmd_valid = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic accept(input logic [7:0] s, input logic d);
        cmd_steps = s;
        cmd_dir = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (q !== 6'b000000) begin bad++; $display("FAIL reset_q got=%b want=000000", q); end
        total++; if (phase !== 4'd0) begin bad++; $display("FAIL reset_phase got=%0d want=0", phase); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted got=%b want=0", aborted); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        rst = 1'b1;
    endtask

    task automatic test_forward;
        logic [5:0] exp_q [3];
        exp_q = '{6'b000001, 6'b000011, 6'b000111};
        do_reset();
        accept(8'd3, 1'b1);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fwd_accept_busy got=%b want=1", busy); end
        total++; if (q !== 6'b000000) begin bad++; $display("FAIL fwd_accept_q got=%b want=000000", q); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (q !== exp_q[i]) begin bad++; $display("FAIL fwd_q%0d got=%b want=%b", i, q, exp_q[i]); end
        end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL fwd_done got=%b want=1", done); end
        total++; if (phase !== 4'd3) begin bad++; $display("FAIL fwd_phase got=%0d want=3", phase); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fwd_done_clear got=%b want=0", done); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL fwd_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_wrap;
        int ndone;
        logic [5:0] last;
        logic [5:0] eq;
        ndone = 0;
        last = '0;
        do_reset();
        accept(8'd13, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            eq = fwd(k <= 13 ? k : 13);
            total++; if (q !== eq) begin bad++; $display("FAIL wrap_q k=%0d got=%b want=%b", k, q, eq); end
            total++; if (phase !== 4'((k <= 13 ? k : 13) % 12)) begin bad++; $display("FAIL wrap_phase k=%0d got=%0d want=%0d", k, phase, (k <= 13 ? k : 13) % 12); end
            if (done) begin
                ndone++;
                last = q;
                total++; if (k !== 13) begin bad++; $display("FAIL wrap_done_cycle got=%0d want=13", k); end
            end
        end
        total++; if (ndone !== 1) begin bad++; $display("FAIL wrap_done_count got=%0d want=1", ndone); end
        total++; if (last !== 6'b000001) begin bad++; $display("FAIL wrap_final_q got=%b want=000001", last); end
    endtask

    task automatic test_reverse;
        do_reset();
        accept(8'd1, 1'b0);
        @(negedge clk);
        total++; if (q !== 6'b100000) begin bad++; $display("FAIL rev_q got=%b want=100000", q); end
        total++; if (phase !== 4'd11) begin bad++; $display("FAIL rev_phase got=%0d want=11", phase); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rev_done got=%b want=1", done); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rev_done_clear got=%b want=0", done); end
    endtask

    task automatic test_abort;
        do_reset();
        accept(8'd10, 1'b1);
        cmd_valid = 1'b1;
        cmd_steps = 8'd0;
        @(negedge clk);
        @(negedge clk);
        total++; if (q !== 6'b000011) begin bad++; $display("FAIL abort_pre_q got=%b want=000011", q); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b want=1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b want=1", done); end
        total++; if (q !== 6'b000011) begin bad++; $display("FAIL abort_hold_q got=%b want=000011", q); end
        total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b want=1", aborted); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", cmd_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_clear got=%b want=0", done); end
        total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_sticky got=%b want=1", aborted); end
        total++; if (q !== 6'b000011) begin bad++; $display("FAIL abort_idle_q got=%b want=000011", q); end
        abort = 1'b1;
        accept(8'd0, 1'b1);
        abort = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        total++; if (q !== 6'b000011) begin bad++; $display("FAIL zero_q got=%b want=000011", q); end
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL zero_aborted_clear got=%b want=0", aborted); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", cmd_ready); end
    endtask

    task automatic test_rst_run;
        do_reset();
        accept(8'd5, 1'b1);
        @(negedge clk);
        total++; if (q !== 6'b000001) begin bad++; $display("FAIL rstrun_pre_q got=%b want=000001", q); end
        rst = 1'b0;
        #1;
        total++; if (q !== 6'b000000) begin bad++; $display("FAIL rstrun_q got=%b want=000000", q); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstrun_busy got=%b want=0", busy); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstrun_ready got=%b want=1", cmd_ready); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rstrun_no_done i=%0d got=%b want=0", i, done); end
        end
    endtask

    task automatic test_back_to_back;
        do_reset();
        accept(8'd2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        total++; if (q !== 6'b000011) begin bad++; $display("FAIL b2b_first_q got=%b want=000011", q); end
        @(negedge clk);
        accept(8'd2, 1'b0);
        @(negedge clk);
        total++; if (q !== 6'b000001) begin bad++; $display("FAIL b2b_mid_q got=%b want=000001", q); end
        @(negedge clk);
        total++; if (q !== 6'b000000) begin bad++; $display("FAIL b2b_q got=%b want=000000", q); end
        total++; if (phase !== 4'd0) begin bad++; $display("FAIL b2b_phase got=%0d want=0", phase); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", done); end
    endtask

`ifdef JC_SELFHEAL_EN
    task automatic test_selfheal;
        do_reset();
        @(negedge clk);
        force dut.u_core.r_q = 6'b010100;
        #1;
        release dut.u_core.r_q;
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL heal_err got=%b want=1", err); end
        @(negedge clk);
        total++; if (q !== 6'b000000) begin bad++; $display("FAIL heal_q got=%b want=000000", q); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL heal_err_clear got=%b want=0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_forward();
        test_wrap();
        test_reverse();
        test_abort();
        test_rst_run();
        test_back_to_back();
`ifdef JC_SELFHEAL_EN
        test_selfheal();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
